// File: rtl/bldc_pwm3_if.sv
// Controller-side signal bundle for the three-phase PWM generator.
// master = commutation/speed controller, slave = bldc_pwm3.
interface bldc_pwm3_if #(
  parameter int unsigned CTR_LEN = 8,
  parameter int unsigned DT_LEN  = 4
);
  logic               enable;
  logic [CTR_LEN-1:0] period;
  logic [CTR_LEN-1:0] compare_a;
  logic [CTR_LEN-1:0] compare_b;
  logic [CTR_LEN-1:0] compare_c;
  logic               load;
  logic [DT_LEN-1:0]  dead_time;
  logic [2:0]         hi;
  logic [2:0]         lo;
  logic               cycle_start;

  modport master (
    output enable, period, compare_a, compare_b, compare_c, load, dead_time,
    input  hi, lo, cycle_start
  );

  modport slave (
    input  enable, period, compare_a, compare_b, compare_c, load, dead_time,
    output hi, lo, cycle_start
  );
endinterface

// File: rtl/bldc_pwm3.sv
// Three-phase PWM with double-buffered compares and per-phase dead-time.
// Define PWM_CENTER_ALIGN_EN for up/down (center-aligned) counting.
module bldc_pwm3 #(
  parameter int unsigned CTR_LEN = 8,
  parameter int unsigned DT_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  bldc_pwm3_if.slave  bus
);

  typedef logic [CTR_LEN-1:0] ctr_t;
  typedef logic [DT_LEN-1:0]  dt_t;

  localparam ctr_t CTR_ONE = ctr_t'(1);
  localparam dt_t  DT_ONE  = dt_t'(1);

  ctr_t       cnt_q, cnt_d;
  ctr_t       pend_q [3];
  ctr_t       pend_d [3];
  ctr_t       act_q  [3];
  ctr_t       act_d  [3];
  ctr_t       cmp_in [3];
  logic       pv_q, pv_d;
  logic [2:0] raw_q, raw_d;
  logic [2:0] hi_q, hi_d;
  logic [2:0] lo_q, lo_d;
  dt_t        dt_q [3];
  dt_t        dt_d [3];
  logic       cs_q, cs_d;
  logic       boundary;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  dir_e dir_q, dir_d;
`endif

  assign cmp_in[0] = bus.compare_a;
  assign cmp_in[1] = bus.compare_b;
  assign cmp_in[2] = bus.compare_c;

  always_comb begin
    boundary = bus.enable && (cnt_q == '0);
    cs_d     = boundary;
    pv_d     = pv_q;
    pend_d   = pend_q;
    act_d    = act_q;
    // Transfer reads pend_q, so a load in the boundary cycle waits a full period.
    if (boundary && pv_q) begin
      act_d = pend_q;
      pv_d  = 1'b0;
    end
    if (bus.load) begin
      pend_d = cmp_in;
      pv_d   = 1'b1;
    end

`ifdef PWM_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (!bus.enable || (bus.period == '0)) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (cnt_q > bus.period) begin
      cnt_d = '0;
      dir_d = DIR_DOWN;
    end else if (cnt_q == '0) begin
      cnt_d = CTR_ONE;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == bus.period) begin
        cnt_d = cnt_q - CTR_ONE;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CTR_ONE;
      end
    end else begin
      cnt_d = cnt_q - CTR_ONE;
    end
`else
    if (!bus.enable || (cnt_q >= bus.period)) cnt_d = '0;
    else                                      cnt_d = cnt_q + CTR_ONE;
`endif

    // Compare against act_d so the boundary cycle already uses the new duty.
    for (int unsigned i = 0; i < 3; i++) begin
      raw_d[i] = act_d[i] > cnt_q;
      if (!bus.enable) begin
        dt_d[i] = bus.dead_time;
        hi_d[i] = 1'b0;
        lo_d[i] = 1'b0;
      end else begin
        hi_d[i] = (dt_q[i] == '0) &&  raw_q[i];
        lo_d[i] = (dt_q[i] == '0) && !raw_q[i];
        if (raw_d[i] != raw_q[i]) dt_d[i] = bus.dead_time;
        else if (dt_q[i] != '0)   dt_d[i] = dt_q[i] - DT_ONE;
        else                      dt_d[i] = dt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= '{default: '0};
      act_q  <= '{default: '0};
      pv_q   <= 1'b0;
      raw_q  <= '0;
      dt_q   <= '{default: '0};
      hi_q   <= '0;
      lo_q   <= '0;
      cs_q   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= DIR_UP;
`endif
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      pv_q   <= pv_d;
      raw_q  <= raw_d;
      dt_q   <= dt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cs_q   <= cs_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q  <= dir_d;
`endif
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.cycle_start = cs_q;

endmodule

// File: tb/tb_bldc_pwm3.sv
// Directed bench for bldc_pwm3: duty, shadow loads, dead-time, disable, reset.
module tb_bldc_pwm3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bldc_pwm3_if #(.CTR_LEN(8), .DT_LEN(4)) bus ();

  bldc_pwm3 #(.CTR_LEN(8), .DT_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int a, input int b, input int c);
    bus.compare_a = 8'(a);
    bus.compare_b = 8'(b);
    bus.compare_c = 8'(c);
    bus.load      = 1'b1;
  endtask

  initial begin
    int          tab [3][4];
    logic [2:0]  eh;
    logic [7:0]  hipat;
    int          p;

    bus.enable    = 1'b0;
    bus.period    = 8'd9;
    bus.compare_a = '0;
    bus.compare_b = '0;
    bus.compare_c = '0;
    bus.load      = 1'b0;
    bus.dead_time = '0;
    rst = 1'b1;
    tick();
    tick();
    check("reset_hi", bus.hi, 3'b000);
    check("reset_lo", bus.lo, 3'b000);
    check("reset_cs", {2'b00, bus.cycle_start}, 3'b000);

`ifdef PWM_CENTER_ALIGN_EN
    // period 4, compare_a 2: counter 0,1,2,3,4,3,2,1 -> raw high at 0,1,...,1
    rst = 1'b0;
    bus.period = 8'd4;
    do_load(2, 0, 0);
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    hipat = 8'b1000_0011;
    for (int n = 1; n <= 24; n++) begin
      tick();
      eh[0] = (n >= 2) ? hipat[(n - 2) % 8] : 1'b0;
      check("ctr_hi", bus.hi, {2'b00, eh[0]});
      check("ctr_lo", bus.lo, {2'b11, ~eh[0]});
      check("ctr_cs", {2'b00, bus.cycle_start}, {2'b00, ((n - 1) % 8) == 0});
    end
`else
    // Run 1: dead_time 0, period 9, shadow-load sequence on B and C
    tab = '{'{3, 3, 3, 3}, '{0, 2, 4, 5}, '{0, 0, 12, 12}};
    rst = 1'b0;
    do_load(3, 0, 0);
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      bus.load = 1'b0;
      if (n == 3)  do_load(3, 7, 0);
      if (n == 5)  do_load(3, 2, 0);
      if (n == 15) do_load(3, 4, 12);
      if (n == 21) do_load(3, 5, 12);
      tick();
      for (int ph = 0; ph < 3; ph++) begin
        if (n >= 2) eh[ph] = tab[ph][(n - 2) / 10] > ((n - 2) % 10);
        else        eh[ph] = 1'b0;
      end
      check("duty_hi", bus.hi, eh);
      check("duty_lo", bus.lo, ~eh);
      check("duty_cs", {2'b00, bus.cycle_start}, {2'b00, ((n - 1) % 10) == 0});
    end
    bus.load = 1'b0;

    // Run 2: dead_time 2, compare_a 5
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.enable    = 1'b0;
    bus.dead_time = 4'd2;
    do_load(5, 0, 0);
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      p = (n - 1) % 10;
      check("dt_hi0", {2'b00, bus.hi[0]}, {2'b00, (p >= 3) && (p <= 5)});
      check("dt_lo0", {2'b00, bus.lo[0]}, {2'b00, (p >= 8) || ((p == 0) && (n > 1))});
      check("dt_excl", bus.hi & bus.lo, 3'b000);
    end

    // Disable mid-run, then re-enable with dead_time 2
    bus.enable = 1'b0;
    tick();
    check("dis_hi", bus.hi, 3'b000);
    check("dis_lo", bus.lo, 3'b000);
    check("dis_cs", {2'b00, bus.cycle_start}, 3'b000);
    tick();
    tick();
    check("dis_hold_lo", bus.lo, 3'b000);
    bus.enable = 1'b1;
    tick();
    check("ren1_hi", bus.hi, 3'b000);
    check("ren1_lo", bus.lo, 3'b000);
    check("ren1_cs", {2'b00, bus.cycle_start}, 3'b001);
    tick();
    check("ren2_hi", bus.hi, 3'b000);
    check("ren2_lo", bus.lo, 3'b000);
    tick();
    check("ren3_hi", bus.hi, 3'b001);
    check("ren3_lo", bus.lo, 3'b110);
    tick();

    // Reset mid-period with enable and load asserted: reset wins
    rst = 1'b1;
    do_load(7, 0, 0);
    tick();
    check("rst_hi", bus.hi, 3'b000);
    check("rst_lo", bus.lo, 3'b000);
    check("rst_cs", {2'b00, bus.cycle_start}, 3'b000);
    rst = 1'b0;
    bus.load      = 1'b0;
    bus.dead_time = '0;
    tick();
    check("post1_cs", {2'b00, bus.cycle_start}, 3'b001);
    check("post1_lo", bus.lo, 3'b111);
    tick();
    check("post2_hi", bus.hi, 3'b000);
    tick();
    check("post3_hi", bus.hi, 3'b000);
    check("post3_lo", bus.lo, 3'b111);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
